// File: rtl/ahb3lite_remote_slave.sv
// ahb3lite_remote_slave
//   AHB3-lite slave that serialises each bus transfer into a byte packet on a
//   TX FIFO and completes the transfer from the host's reply on an RX FIFO.
//   Packet: CMD {HWRITE, posted, HSIZE[1:0], 4'h0}, ADDR_BYTES address bytes
//   LSB first, then 4 write-data bytes LSB first (writes only).
//   Reply: one status byte (0x00 = OKAY), then 4 read-data bytes for reads.
//   Optional feature macro: FLEXSOC_REMOTE_POSTED_WR_EN. When defined, writes
//   are posted: CMD bit6 is set and the write completes without a reply.
module ahb3lite_remote_slave #(
  parameter int ADDR_BYTES = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic        WREN,
  input  logic        WRFULL,
  output logic [7:0]  WRDATA,
  output logic        RDEN,
  input  logic        RDEMPTY,
  input  logic [7:0]  RDDATA
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_CMD   = 4'd1;
  localparam logic [3:0] S_ADDR  = 4'd2;
  localparam logic [3:0] S_WDATA = 4'd3;
  localparam logic [3:0] S_RESP  = 4'd4;
  localparam logic [3:0] S_RDATA = 4'd5;
  localparam logic [3:0] S_DONE  = 4'd6;
  localparam logic [3:0] S_ERR1  = 4'd7;
  localparam logic [3:0] S_ERR2  = 4'd8;

  localparam logic [1:0] LAST_ADDR = 2'(ADDR_BYTES - 1);

  logic [3:0]  state;
  logic [1:0]  cnt;
  logic [31:0] addr_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic        wdata_cap;
  logic        rd_wait;
  logic [23:0] rd_buf;
  logic        posted;
  logic        accept;
  logic        can_accept;
  logic        tx_active;
  logic        tx_push;
  logic        rx_active;
  logic        rd_issue;
  logic        rd_take;
  logic [7:0]  tx_byte;

`ifdef FLEXSOC_REMOTE_POSTED_WR_EN
  assign posted = write_q;
`else
  assign posted = 1'b0;
`endif

  // Pick byte 'idx' (0 = least significant) out of a 32-bit word
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    byte_of = w[7:0];
      2'd1:    byte_of = w[15:8];
      2'd2:    byte_of = w[23:16];
      default: byte_of = w[31:24];
    endcase
  endfunction

  assign accept     = HSEL & HREADY & HTRANS[1];
  assign can_accept = (state == S_IDLE) | (state == S_DONE) | (state == S_ERR2);
  assign tx_active  = (state == S_CMD) | (state == S_ADDR) | (state == S_WDATA);
  assign rx_active  = (state == S_RESP) | (state == S_RDATA);

  // FIFO handshakes are gated by RESET so nothing moves in the reset cycle
  assign tx_push  = tx_active & ~WRFULL & ~RESET;
  assign rd_issue = rx_active & ~rd_wait & ~RDEMPTY & ~RESET;
  assign rd_take  = rx_active & rd_wait;

  assign WREN      = tx_push;
  assign RDEN      = rd_issue;
  assign WRDATA    = tx_byte;
  assign HREADYOUT = can_accept;
  assign HRESP     = (state == S_ERR1) | (state == S_ERR2);

  // Select the packet byte presented to the TX FIFO in the current state
  always_comb begin
    tx_byte = 8'h00;
    case (state)
      S_CMD:   tx_byte = {write_q, posted, size_q, 4'h0};
      S_ADDR:  tx_byte = byte_of(addr_q, cnt);
      S_WDATA: tx_byte = byte_of(wdata_q, cnt);
      default: tx_byte = 8'h00;
    endcase
  end

  // Transfer sequencing: accept, packet transmit, reply receive, completion
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      cnt       <= 2'd0;
      addr_q    <= 32'h0;
      write_q   <= 1'b0;
      size_q    <= 2'd0;
      wdata_q   <= 32'h0;
      wdata_cap <= 1'b0;
      rd_wait   <= 1'b0;
      rd_buf    <= 24'h0;
      HRDATA    <= 32'h0;
    end else begin
      wdata_cap <= 1'b0;
      if (wdata_cap)
        wdata_q <= HWDATA;

      if (rd_issue)
        rd_wait <= 1'b1;
      else if (rd_take)
        rd_wait <= 1'b0;

      case (state)
        S_IDLE, S_DONE, S_ERR2: begin
          if (accept) begin
            addr_q    <= HADDR;
            write_q   <= HWRITE;
            size_q    <= HSIZE[1:0];
            wdata_cap <= 1'b1;
            cnt       <= 2'd0;
            state     <= (HSIZE > 3'd2) ? S_ERR1 : S_CMD;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CMD: begin
          if (tx_push) begin
            cnt   <= 2'd0;
            state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (tx_push) begin
            if (cnt == LAST_ADDR) begin
              cnt   <= 2'd0;
              state <= write_q ? S_WDATA : S_RESP;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        S_WDATA: begin
          if (tx_push) begin
            if (cnt == 2'd3) begin
              cnt   <= 2'd0;
              state <= posted ? S_DONE : S_RESP;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        S_RESP: begin
          if (rd_take) begin
            cnt <= 2'd0;
            if (RDDATA != 8'h00)
              state <= S_ERR1;
            else
              state <= write_q ? S_DONE : S_RDATA;
          end
        end
        S_RDATA: begin
          if (rd_take) begin
            case (cnt)
              2'd0:    rd_buf[7:0]   <= RDDATA;
              2'd1:    rd_buf[15:8]  <= RDDATA;
              2'd2:    rd_buf[23:16] <= RDDATA;
              default: HRDATA        <= {RDDATA, rd_buf};
            endcase
            if (cnt == 2'd3) begin
              cnt   <= 2'd0;
              state <= S_DONE;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        S_ERR1: begin
          cnt   <= 2'd0;
          state <= S_ERR2;
        end
        default: begin
          cnt   <= 2'd0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
